uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte buffer and issue controller directly upstream of the UART transmit FSM/serializer.
- Accepts bytes from a system-side write port into a FIFO.
- Presents one byte at a time on P_DATA with a one-cycle Data_Valid pulse.
- Uses the transmitter's registered Busy to pace issue, so back-to-back writes are transmitted without loss or duplication.

Parameters:
- DATA_WIDTH, 8, width of each byte and of P_DATA.
- FIFO_DEPTH, 8, number of FIFO entries; power of two, >= 2.
- BUSY_TIMEOUT, 4, cycles to wait for Busy to rise after a Data_Valid pulse before re-issuing.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  reset; synchronous and active-high.
- Wr_En  in  1  write strobe; Wr_Data is sampled on a rising edge with Wr_En=1.
- Wr_Data  in  DATA_WIDTH  byte to enqueue.
- Busy  in  1  transmitter busy; registered in the transmitter; rises 2 cycles after an accepted Data_Valid.
- P_DATA  out  DATA_WIDTH  byte being transmitted; registered.
- Data_Valid  out  1  one-cycle issue pulse to the transmitter; registered.
- Full  out  1  FIFO holds FIFO_DEPTH entries.
- Empty  out  1  FIFO holds 0 entries.
- Fifo_Count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- Overflow  out  1  sticky flag: a write was dropped.

Behaviour:
- Reset (RST=1 at rising edge):
  - FIFO pointers and count = 0, so Empty=1, Full=0, Fifo_Count=0.
  - P_DATA=0, Data_Valid=0, Overflow=0, retry counter=0, state=IDLE.
  - Reset mid-transfer discards all queued bytes. The transmitter is reset by the same RST.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - Full/Empty/Fifo_Count are derived from the registered count.
- Write rules:
  - Wr_En while not Full: enqueue; count increments at the edge.
  - Wr_En while Full: byte dropped, Overflow set; Overflow is cleared only by reset.
  - Wr_En while Full in the same cycle as a pop: write accepted, count unchanged, Overflow not set.
  - Wr_En while Empty in the same cycle as a pop cannot occur (a pop requires !Empty).
- FSM states:
  - IDLE:
    - Data_Valid=0.
    - If !Empty && !Busy: pop the head into P_DATA, assert Data_Valid next cycle, go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE:
    - Data_Valid=1 for exactly this cycle; clear the retry counter.
    - Go to WAIT_BUSY.
  - WAIT_BUSY:
    - Data_Valid=0; the retry counter increments each cycle.
    - If Busy=1: go to WAIT_DONE.
    - Else if counter reaches BUSY_TIMEOUT: go to ISSUE, re-pulsing with P_DATA unchanged (no pop).
  - WAIT_DONE:
    - Data_Valid=0.
    - When Busy=0: go to IDLE.
- Latency:
  - Write accepted at edge k into an empty FIFO with Busy=0 → pop at edge k+1 → Data_Valid high in the cycle after edge k+1.
  - Fifo_Count drops at edge k+1.
- Data path:
  - P_DATA changes only on a pop and is stable through ISSUE, WAIT_BUSY and WAIT_DONE.
  - The transmitter therefore sees a stable byte for the whole frame.
- Back-to-back:
  - The next pop occurs no earlier than the first IDLE cycle after Busy falls.
  - Minimum gap: Busy low for 1 cycle between frames.
- Sequencing guarantees:
  - Data_Valid is never asserted in two consecutive cycles.
  - Data_Valid is never asserted while Busy=1.
  - Bytes leave in write order; none is duplicated except by a timeout re-issue.
- Illegal state encodings return to IDLE.

Test Plan:
- Reset, then write 0xA5 with Busy model responding 2 cycles after pulse and holding for 10 cycles → Data_Valid one cycle high, 2 edges after the write; P_DATA=0xA5 stable until Busy falls; Empty=1 afterwards.
- Burst-write 0x01..0x08 (FIFO_DEPTH=8) in consecutive cycles → Full=1 after the 8th write; transmitter receives 0x01..0x08 in order, exactly 8 pulses, each issued only after Busy drops.
- With Busy held high, write 9 bytes → Full=1, Overflow=1, Fifo_Count=8; the 9th byte is never transmitted.
- Full FIFO: write 0x55 in the same cycle as a pop → Fifo_Count stays 8, Overflow stays 0, and 0x55 is transmitted last.
- Busy model ignores the first pulse → after BUSY_TIMEOUT=4 cycles Data_Valid re-pulses with the same P_DATA, no pop occurs, and Fifo_Count is unchanged.
- Assert RST in WAIT_DONE with 3 bytes queued → next cycle Empty=1, Fifo_Count=0, Data_Valid=0, P_DATA=0, Overflow=0, state IDLE.

Source files
------------

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: the feeder's bus. Carries the system-side write port,
// the transmitter handshake (P_DATA/Data_Valid/Busy) and FIFO status.
//
// Modports:
//   master : environment side; drives Wr_En, Wr_Data, Busy and observes the rest.
//   slave  : feeder side; consumes Wr_En, Wr_Data, Busy and drives P_DATA,
//            Data_Valid, Full, Empty, Fifo_Count, Overflow.
interface uart_tx_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic                  Wr_En;
  logic [DATA_WIDTH-1:0] Wr_Data;
  logic                  Busy;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  Full;
  logic                  Empty;
  logic [CntW-1:0]       Fifo_Count;
  logic                  Overflow;

  modport master (
    output Wr_En,
    output Wr_Data,
    output Busy,
    input  P_DATA,
    input  Data_Valid,
    input  Full,
    input  Empty,
    input  Fifo_Count,
    input  Overflow
  );

  modport slave (
    input  Wr_En,
    input  Wr_Data,
    input  Busy,
    output P_DATA,
    output Data_Valid,
    output Full,
    output Empty,
    output Fifo_Count,
    output Overflow
  );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus issue controller sitting in front of a UART
// transmitter. Bytes written on the system side are queued, then handed to the
// transmitter one at a time as a registered P_DATA with a one-cycle Data_Valid
// pulse, paced by the transmitter's registered Busy.
//
// Ports:
//   CLK  : clock, rising edge.
//   RST  : synchronous active-high reset; discards all queued bytes.
//   bus  : uart_tx_feeder_if.slave
//          Wr_En/Wr_Data  write port (byte sampled on a rising edge with Wr_En=1)
//          Busy           transmitter busy, rises 2 cycles after an accepted pulse
//          P_DATA         byte being transmitted (registered, stable per frame)
//          Data_Valid     one-cycle issue pulse (registered)
//          Full/Empty     FIFO occupancy flags
//          Fifo_Count     current occupancy
//          Overflow       sticky: a write was dropped while full
module uart_tx_feeder #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input logic               CLK,
  input logic               RST,
  uart_tx_feeder_if.slave   bus
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned RetryW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [CntW-1:0]   CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StIssue    = 2'd1,
    StWaitBusy = 2'd2,
    StWaitDone = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  overflow_q;

  // Issue controller
  state_e                state_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic [RetryW-1:0]     retry_q;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntFull);

  // A pop only happens from IDLE with the transmitter idle; it frees a slot in
  // the same cycle, so a write against a full FIFO is still accepted then.
  assign pop  = (state_q == StIdle) && !empty && !bus.Busy;
  assign push = bus.Wr_En && (!full || pop);
  assign drop = bus.Wr_En && full && !pop;

  // Storage needs no reset: stale entries are never read once pointers clear.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.Wr_Data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Data_Valid is registered, so it is raised on the edge that enters ISSUE and
  // is therefore high for exactly the ISSUE cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      retry_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          data_valid_q <= 1'b0;
          if (pop) begin
            p_data_q     <= mem_q[rd_ptr_q];
            data_valid_q <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          data_valid_q <= 1'b0;
          retry_q      <= '0;
          state_q      <= StWaitBusy;
        end
        StWaitBusy: begin
          data_valid_q <= 1'b0;
          retry_q      <= retry_q + RetryW'(1);
          if (bus.Busy) begin
            state_q <= StWaitDone;
          end else if (retry_q + RetryW'(1) == RetryMax) begin
            // Transmitter missed the pulse: re-issue the same byte, no pop.
            data_valid_q <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StWaitDone: begin
          data_valid_q <= 1'b0;
          if (!bus.Busy) begin
            state_q <= StIdle;
          end
        end
        default: begin
          data_valid_q <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign bus.P_DATA     = p_data_q;
  assign bus.Data_Valid = data_valid_q;
  assign bus.Full       = full;
  assign bus.Empty      = empty;
  assign bus.Fifo_Count = count_q;
  assign bus.Overflow   = overflow_q;

  // Sequencing invariants.
  a_dv_single: assert property (@(posedge CLK) disable iff (RST)
    data_valid_q |=> !data_valid_q);
  a_count_bound: assert property (@(posedge CLK) disable iff (RST)
    count_q <= CntFull);
  a_pdata_hold: assert property (@(posedge CLK) disable iff (RST)
    !pop |=> $stable(p_data_q));

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int TO    = 4;
  localparam int HOLD  = 10;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  uart_tx_feeder_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q [$];

  // Transmitter model state
  logic          model_busy = 1'b0;
  logic          pend       = 1'b0;
  logic          dv_q       = 1'b0;
  logic          busy_hold  = 1'b0;
  int            hold_cnt   = 0;
  int            rx_cnt     = 0;
  int            ignored_cnt   = 0;
  int            ignore_target = 0;
  logic [DW-1:0] cur_byte   = '0;

  assign bus.Busy = model_busy | busy_hold;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model: Busy rises 2 cycles after an accepted pulse and stays
  // high for HOLD cycles. It can be told to ignore pulses to force a re-issue.
  always @(posedge CLK) begin
    if (RST) begin
      model_busy <= 1'b0;
      pend       <= 1'b0;
      hold_cnt   <= 0;
      dv_q       <= 1'b0;
    end else begin
      dv_q <= bus.Data_Valid;
      if (bus.Data_Valid) begin
        check("dv_while_busy", 32'(bus.Busy), 32'd0);
        check("dv_back_to_back", 32'(dv_q), 32'd0);
        if (ignored_cnt < ignore_target) begin
          ignored_cnt <= ignored_cnt + 1;
        end else begin
          rx_cnt   <= rx_cnt + 1;
          cur_byte <= bus.P_DATA;
          pend     <= 1'b1;
          if (exp_q.size() == 0) begin
            // No byte was expected; 0x100 cannot match any byte.
            check("extra_byte", 32'(bus.P_DATA), 32'h100);
          end else begin
            check("byte_order", 32'(bus.P_DATA), 32'(exp_q.pop_front()));
          end
        end
      end
      if (pend) begin
        pend       <= 1'b0;
        model_busy <= 1'b1;
        hold_cnt   <= HOLD - 1;
      end else if (model_busy) begin
        if (hold_cnt == 0) model_busy <= 1'b0;
        else hold_cnt <= hold_cnt - 1;
      end
      if (model_busy) check("pdata_stable", 32'(bus.P_DATA), 32'(cur_byte));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input bit expect_tx);
    bus.Wr_En   = 1'b1;
    bus.Wr_Data = d;
    if (expect_tx) exp_q.push_back(d);
    tick();
    bus.Wr_En = 1'b0;
  endtask

  task automatic drain(input int exp_rx);
    int n = 0;
    while (!(exp_q.size() == 0 && !pend && !model_busy && !bus.Data_Valid && bus.Empty)
           && n < 400) begin
      tick();
      n++;
    end
    repeat (8) tick();
    check("drain_timeout", 32'(n >= 400), 32'd0);
    check("rx_count", 32'(rx_cnt), 32'(exp_rx));
    check("empty_after", 32'(bus.Empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bus.Wr_En   = 1'b0;
    bus.Wr_Data = '0;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // Reset state
    check("rst_empty", 32'(bus.Empty), 32'd1);
    check("rst_full", 32'(bus.Full), 32'd0);
    check("rst_count", 32'(bus.Fifo_Count), 32'd0);
    check("rst_dv", 32'(bus.Data_Valid), 32'd0);
    check("rst_pdata", 32'(bus.P_DATA), 32'd0);
    check("rst_ovf", 32'(bus.Overflow), 32'd0);

    // Single byte: pop one edge after the write edge, pulse the following cycle
    wr(8'hA5, 1'b1);
    check("t1_count1", 32'(bus.Fifo_Count), 32'd1);
    check("t1_dv_early", 32'(bus.Data_Valid), 32'd0);
    tick();
    check("t1_dv", 32'(bus.Data_Valid), 32'd1);
    check("t1_pdata", 32'(bus.P_DATA), 32'hA5);
    check("t1_count0", 32'(bus.Fifo_Count), 32'd0);
    tick();
    check("t1_dv_low", 32'(bus.Data_Valid), 32'd0);
    drain(1);

    // Burst of 8 with the transmitter held busy, then released
    busy_hold = 1'b1;
    for (int i = 1; i <= 8; i++) wr(8'(i), 1'b1);
    check("t2_full", 32'(bus.Full), 32'd1);
    check("t2_count", 32'(bus.Fifo_Count), 32'd8);
    check("t2_ovf", 32'(bus.Overflow), 32'd0);
    busy_hold = 1'b0;
    drain(9);

    // Nine writes while busy: ninth is dropped and flagged
    busy_hold = 1'b1;
    for (int i = 0; i < 9; i++) wr(8'(8'h20 + i), i < 8);
    check("t3_full", 32'(bus.Full), 32'd1);
    check("t3_ovf", 32'(bus.Overflow), 32'd1);
    check("t3_count", 32'(bus.Fifo_Count), 32'd8);
    busy_hold = 1'b0;
    drain(17);
    check("t3_ovf_sticky", 32'(bus.Overflow), 32'd1);

    // Write into a full FIFO on the same cycle as a pop
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t4_ovf_cleared", 32'(bus.Overflow), 32'd0);
    busy_hold = 1'b1;
    for (int i = 0; i < 8; i++) wr(8'(8'h10 + i), 1'b1);
    check("t4_full", 32'(bus.Fifo_Count), 32'd8);
    busy_hold   = 1'b0;
    bus.Wr_En   = 1'b1;
    bus.Wr_Data = 8'h55;
    exp_q.push_back(8'h55);
    tick();
    bus.Wr_En = 1'b0;
    check("t4_count", 32'(bus.Fifo_Count), 32'd8);
    check("t4_ovf", 32'(bus.Overflow), 32'd0);
    check("t4_dv", 32'(bus.Data_Valid), 32'd1);
    check("t4_pdata", 32'(bus.P_DATA), 32'h10);
    drain(26);

    // Transmitter ignores the first pulse: re-issue after the timeout
    ignore_target = 1;
    wr(8'h3C, 1'b1);
    wr(8'h3D, 1'b1);
    check("t5_dv", 32'(bus.Data_Valid), 32'd1);
    check("t5_pdata", 32'(bus.P_DATA), 32'h3C);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.Data_Valid && n < 20);
    check("t5_retry_gap", 32'(n), 32'(TO + 1));
    check("t5_pdata_retry", 32'(bus.P_DATA), 32'h3C);
    check("t5_count", 32'(bus.Fifo_Count), 32'd1);
    drain(28);

    // Reset while the transmitter is busy with 3 bytes queued
    wr(8'h71, 1'b1);
    n = 0;
    while (!model_busy && n < 20) begin
      tick();
      n++;
    end
    check("t6_busy_seen", 32'(model_busy), 32'd1);
    for (int i = 0; i < 3; i++) wr(8'(8'hE0 + i), 1'b0);
    check("t6_queued", 32'(bus.Fifo_Count), 32'd3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_empty", 32'(bus.Empty), 32'd1);
    check("t6_count", 32'(bus.Fifo_Count), 32'd0);
    check("t6_dv", 32'(bus.Data_Valid), 32'd0);
    check("t6_pdata", 32'(bus.P_DATA), 32'd0);
    check("t6_ovf", 32'(bus.Overflow), 32'd0);
    drain(29);
    // Controller must be back in IDLE and issue normally
    wr(8'h99, 1'b1);
    tick();
    check("t6_dv_after", 32'(bus.Data_Valid), 32'd1);
    check("t6_pdata_after", 32'(bus.P_DATA), 32'h99);
    drain(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
